// File: rtl/sram_bridge.sv
// Bridges a DSIZE-bit CPU bus onto a narrower asynchronous SRAM, splitting each access
// into BEATS sequential RSIZE-bit beats with programmable strobe length.
module sram_bridge #(
    parameter int DSIZE       = 32,
    parameter int RSIZE       = 16,
    parameter int ASIZE       = 20,
    parameter int RAM_ASIZE   = 18,
    parameter int WAIT_STATES = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ext_cs_b,
    input  logic                 cpu_rnw,
    input  logic [ASIZE-1:0]     cpu_addr,
    input  logic [DSIZE-1:0]     cpu_dout,
    output logic                 cpu_clken,
    output logic [DSIZE-1:0]     ext_dout,
    output logic                 ram_cs_b,
    output logic                 ram_oe_b,
    output logic                 ram_we_b,
    output logic [RAM_ASIZE-1:0] ram_addr,
    input  logic [RSIZE-1:0]     ram_data_in,
    output logic [RSIZE-1:0]     ram_data_out,
    output logic                 ram_data_oe
);

    localparam int BEATS = DSIZE / RSIZE;
    localparam int L     = $clog2(BEATS);
    localparam int BW    = (L > 0) ? L : 1;

    generate
        if ((BEATS < 1) || (BEATS * RSIZE != DSIZE) || ((BEATS & (BEATS - 1)) != 0)) begin : g_bad_beats
            $error("sram_bridge: DSIZE/RSIZE must be a power of two >= 1");
        end
        if ((WAIT_STATES < 0) || (WAIT_STATES > 15)) begin : g_bad_wait
            $error("sram_bridge: WAIT_STATES must be in 0..15");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RSTB   = 3'd1,
        WSETUP = 3'd2,
        WSTB   = 3'd3,
        WHOLD  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [BW-1:0]     beat_r, beat_nxt_s;
    logic [3:0]        wait_r, wait_nxt_s;
    logic              last_wait_s, last_beat_s;
    logic [RSIZE-1:0]  wr_slice_s;
    logic              cs_r, oe_r, we_r, doe_r;
    logic [RSIZE-1:0]  dout_r;
    logic [DSIZE-1:0]  ext_dout_r;
    logic              addr_unused_s;

    assign last_wait_s   = (wait_r == 4'(WAIT_STATES));
    assign last_beat_s   = (beat_r == BW'(BEATS - 1));
    assign addr_unused_s = ^cpu_addr;

    generate
        if (BEATS > 1) begin : g_multi
            assign ram_addr = {cpu_addr[RAM_ASIZE-L-1:0], beat_r[L-1:0]};
        end else begin : g_single
            assign ram_addr = cpu_addr[RAM_ASIZE-1:0];
        end
    endgenerate

    assign cpu_clken    = ext_cs_b | (state_r == DONE);
    assign ram_cs_b     = cs_r;
    assign ram_oe_b     = oe_r;
    assign ram_we_b     = we_r;
    assign ram_data_oe  = doe_r;
    assign ram_data_out = dout_r;
    assign ext_dout     = ext_dout_r;

    // State, beat and wait-state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            beat_r  <= '0;
            wait_r  <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            beat_r  <= beat_nxt_s;
            wait_r  <= wait_nxt_s;
        end
    end

    // Next-state sequencing of beats, strobes and write setup/hold
    always_comb begin
        state_nxt_s = state_r;
        beat_nxt_s  = beat_r;
        wait_nxt_s  = wait_r;
        case (state_r)
            IDLE: begin
                if (!ext_cs_b) begin
                    beat_nxt_s  = '0;
                    wait_nxt_s  = 4'd0;
                    state_nxt_s = cpu_rnw ? RSTB : WSETUP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RSTB: begin
                if (last_wait_s) begin
                    wait_nxt_s = 4'd0;
                    if (last_beat_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        beat_nxt_s  = beat_r + BW'(1);
                        state_nxt_s = RSTB;
                    end
                end else begin
                    wait_nxt_s = wait_r + 4'd1;
                end
            end
            WSETUP: begin
                wait_nxt_s  = 4'd0;
                state_nxt_s = WSTB;
            end
            WSTB: begin
                if (last_wait_s) begin
                    wait_nxt_s  = 4'd0;
                    state_nxt_s = WHOLD;
                end else begin
                    wait_nxt_s = wait_r + 4'd1;
                end
            end
            WHOLD: begin
                if (last_beat_s) begin
                    state_nxt_s = DONE;
                end else begin
                    beat_nxt_s  = beat_r + BW'(1);
                    state_nxt_s = WSETUP;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Select the CPU write-data slice for the upcoming beat
    always_comb begin
        wr_slice_s = '0;
        for (int i = 0; i < BEATS; i++) begin
            wr_slice_s = (beat_nxt_s == BW'(i)) ? cpu_dout[i*RSIZE +: RSIZE] : wr_slice_s;
        end
    end

    // Pad strobes are registered from the next state so they align with the state itself
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cs_r   <= 1'b1;
            oe_r   <= 1'b1;
            we_r   <= 1'b1;
            doe_r  <= 1'b0;
            dout_r <= '0;
        end else begin
            case (state_nxt_s)
                RSTB: begin
                    cs_r <= 1'b0; oe_r <= 1'b0; we_r <= 1'b1; doe_r <= 1'b0; dout_r <= '0;
                end
                WSETUP, WHOLD: begin
                    cs_r <= 1'b0; oe_r <= 1'b1; we_r <= 1'b1; doe_r <= 1'b1; dout_r <= wr_slice_s;
                end
                WSTB: begin
                    cs_r <= 1'b0; oe_r <= 1'b1; we_r <= 1'b0; doe_r <= 1'b1; dout_r <= wr_slice_s;
                end
                default: begin
                    cs_r <= 1'b1; oe_r <= 1'b1; we_r <= 1'b1; doe_r <= 1'b0; dout_r <= '0;
                end
            endcase
        end
    end

    // Read capture into the slice of the current beat on the last strobe cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ext_dout_r <= '0;
        end else begin
            for (int i = 0; i < BEATS; i++) begin
                if ((state_r == RSTB) && last_wait_s && (beat_r == BW'(i))) begin
                    ext_dout_r[i*RSIZE +: RSIZE] <= ram_data_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_bridge.sv
// Directed bench for sram_bridge: a default 32/16 two-beat instance and a 16/16
// single-beat zero-wait instance, with a small SRAM read model and write capture.
module tb_sram_bridge;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    always #5 clock = ~clock;

    logic        ext_cs_b, cpu_rnw, cpu_clken;
    logic [19:0] cpu_addr;
    logic [31:0] cpu_dout, ext_dout;
    logic        ram_cs_b, ram_oe_b, ram_we_b, ram_data_oe;
    logic [17:0] ram_addr;
    logic [15:0] ram_data_in, ram_data_out;

    logic        ext_cs_b1, cpu_rnw1, cpu_clken1;
    logic [19:0] cpu_addr1;
    logic [15:0] cpu_dout1, ext_dout1;
    logic        ram_cs_b1, ram_oe_b1, ram_we_b1, ram_data_oe1;
    logic [17:0] ram_addr1;
    logic [15:0] ram_data_in1, ram_data_out1;

    sram_bridge dut (
        .clock(clock), .reset(reset), .ext_cs_b(ext_cs_b), .cpu_rnw(cpu_rnw),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_clken(cpu_clken), .ext_dout(ext_dout),
        .ram_cs_b(ram_cs_b), .ram_oe_b(ram_oe_b), .ram_we_b(ram_we_b), .ram_addr(ram_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .ram_data_oe(ram_data_oe)
    );

    sram_bridge #(.DSIZE(16), .RSIZE(16), .ASIZE(20), .RAM_ASIZE(18), .WAIT_STATES(0)) dut1 (
        .clock(clock), .reset(reset), .ext_cs_b(ext_cs_b1), .cpu_rnw(cpu_rnw1),
        .cpu_addr(cpu_addr1), .cpu_dout(cpu_dout1), .cpu_clken(cpu_clken1), .ext_dout(ext_dout1),
        .ram_cs_b(ram_cs_b1), .ram_oe_b(ram_oe_b1), .ram_we_b(ram_we_b1), .ram_addr(ram_addr1),
        .ram_data_in(ram_data_in1), .ram_data_out(ram_data_out1), .ram_data_oe(ram_data_oe1)
    );

    assign ram_data_in  = (ram_addr == 18'h00246) ? 16'hBEEF :
                          (ram_addr == 18'h00247) ? 16'hDEAD : 16'h0000;
    assign ram_data_in1 = (ram_addr1 == 18'h3FFFF) ? 16'h1234 : 16'h0000;

    int vectors = 0;
    int errors  = 0;
    int we_low = 0, contention = 0, dones = 0;
    logic [15:0] wmem [0:1023];

    // SRAM write capture and bus-activity counters
    always @(negedge clock) begin
        if (!reset) begin
            if (!ram_we_b && !ram_cs_b) wmem[ram_addr[9:0]] <= ram_data_out;
            if (!ram_we_b) we_low <= we_low + 1;
            if (ram_data_oe && !ram_oe_b) contention <= contention + 1;
            if (!ext_cs_b && cpu_clken) dones <= dones + 1;
        end
    end

    // Starts an access on dut at posedge+1; returns at the negedge of DONE
    task automatic access(input logic rnw, input logic [19:0] a, input logic [31:0] d, output int cyc);
        cpu_rnw = rnw; cpu_addr = a; cpu_dout = d; ext_cs_b = 1'b0;
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (!cpu_clken && cyc < 100);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #1;
        vectors++;
        if ({ram_cs_b, ram_oe_b, ram_we_b, ram_data_oe} !== 4'b1110) begin
            errors++; $display("FAIL reset_strobes: got %b want 1110", {ram_cs_b, ram_oe_b, ram_we_b, ram_data_oe});
        end
        vectors++;
        if (ext_dout !== 32'h0 || ram_data_out !== 16'h0) begin
            errors++; $display("FAIL reset_data: ext_dout=%h data_out=%h want 0/0", ext_dout, ram_data_out);
        end
        vectors++;
        if (cpu_clken !== 1'b1) begin
            errors++; $display("FAIL reset_clken: got %b want 1", cpu_clken);
        end
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_idle;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            vectors++;
            if ({cpu_clken, ram_cs_b, ram_oe_b, ram_we_b, ram_data_oe} !== 5'b11110) begin
                errors++; $display("FAIL idle_%0d: got %b want 11110", i, {cpu_clken, ram_cs_b, ram_oe_b, ram_we_b, ram_data_oe});
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic test_read;
        int cyc;
        access(1'b1, 20'h00123, 32'h0, cyc);
        vectors++;
        if (cyc != 6) begin errors++; $display("FAIL read_cycles: got %0d want 6", cyc); end
        vectors++;
        if (ext_dout !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data: got %h want deadbeef", ext_dout); end
        @(posedge clock); #1;
        ext_cs_b = 1'b1;
    endtask

    task automatic test_write;
        int cyc, w0;
        w0 = we_low;
        access(1'b0, 20'h00010, 32'hCAFEF00D, cyc);
        vectors++;
        if (cyc != 10) begin errors++; $display("FAIL write_cycles: got %0d want 10", cyc); end
        @(posedge clock); #1;
        ext_cs_b = 1'b1;
        @(negedge clock);
        vectors++;
        if (wmem[10'h020] !== 16'hF00D || wmem[10'h021] !== 16'hCAFE) begin
            errors++; $display("FAIL write_data: got %h/%h want f00d/cafe", wmem[10'h020], wmem[10'h021]);
        end
        vectors++;
        if (we_low - w0 != 4) begin errors++; $display("FAIL write_we_cycles: got %0d want 4", we_low - w0); end
        vectors++;
        if (ext_dout !== 32'hDEADBEEF) begin errors++; $display("FAIL write_keeps_dout: got %h want deadbeef", ext_dout); end
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back;
        int cyc1, cyc2, d0, c0;
        d0 = dones; c0 = contention;
        access(1'b1, 20'h00123, 32'h0, cyc1);
        vectors++;
        if (cyc1 != 6 || ext_dout !== 32'hDEADBEEF) begin
            errors++; $display("FAIL b2b_read: cycles=%0d data=%h want 6/deadbeef", cyc1, ext_dout);
        end
        @(posedge clock); #1;
        access(1'b0, 20'h00040, 32'h89AB4567, cyc2);
        vectors++;
        if (cyc2 != 10) begin errors++; $display("FAIL b2b_write_cycles: got %0d want 10", cyc2); end
        @(posedge clock); #1;
        ext_cs_b = 1'b1;
        @(negedge clock);
        vectors++;
        if (wmem[10'h080] !== 16'h4567 || wmem[10'h081] !== 16'h89AB) begin
            errors++; $display("FAIL b2b_write_data: got %h/%h want 4567/89ab", wmem[10'h080], wmem[10'h081]);
        end
        vectors++;
        if (dones - d0 != 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", dones - d0); end
        vectors++;
        if (contention - c0 != 0) begin errors++; $display("FAIL b2b_contention: got %0d want 0", contention - c0); end
        @(posedge clock); #1;
    endtask

    task automatic test_single_beat;
        int cyc;
        cpu_rnw1 = 1'b1; cpu_addr1 = 20'h3FFFF; ext_cs_b1 = 1'b0;
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
            if (cyc == 2) begin
                vectors++;
                if (ram_addr1 !== 18'h3FFFF || ram_oe_b1 !== 1'b0) begin
                    errors++; $display("FAIL single_addr: addr=%h oe_b=%b want 3ffff/0", ram_addr1, ram_oe_b1);
                end
            end
        end while (!cpu_clken1 && cyc < 100);
        vectors++;
        if (cyc != 3) begin errors++; $display("FAIL single_cycles: got %0d want 3", cyc); end
        vectors++;
        if (ext_dout1 !== 16'h1234) begin errors++; $display("FAIL single_data: got %h want 1234", ext_dout1); end
        @(posedge clock); #1;
        ext_cs_b1 = 1'b1;
    endtask

    task automatic test_reset_midbeat;
        int cyc;
        cpu_rnw = 1'b0; cpu_addr = 20'h00030; cpu_dout = 32'h12345678; ext_cs_b = 1'b0;
        repeat (7) @(negedge clock);
        vectors++;
        if (ram_we_b !== 1'b0 || ram_data_out !== 16'h1234) begin
            errors++; $display("FAIL midbeat_strobe: we_b=%b data=%h want 0/1234", ram_we_b, ram_data_out);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({ram_cs_b, ram_oe_b, ram_we_b, ram_data_oe} !== 4'b1110 || ext_dout !== 32'h0) begin
            errors++; $display("FAIL midbeat_reset: strobes=%b dout=%h want 1110/0",
                               {ram_cs_b, ram_oe_b, ram_we_b, ram_data_oe}, ext_dout);
        end
        vectors++;
        if (cpu_clken !== 1'b0) begin errors++; $display("FAIL midbeat_clken_low: got %b want 0", cpu_clken); end
        ext_cs_b = 1'b1;
        #1;
        vectors++;
        if (cpu_clken !== 1'b1) begin errors++; $display("FAIL midbeat_clken_high: got %b want 1", cpu_clken); end
        @(negedge clock) reset = 1'b0;
        @(posedge clock); #1;
        access(1'b1, 20'h00123, 32'h0, cyc);
        vectors++;
        if (cyc != 6 || ext_dout !== 32'hDEADBEEF) begin
            errors++; $display("FAIL post_reset_read: cycles=%0d data=%h want 6/deadbeef", cyc, ext_dout);
        end
        @(posedge clock); #1;
        ext_cs_b = 1'b1;
    endtask

    initial begin
        ext_cs_b = 1'b1; cpu_rnw = 1'b1; cpu_addr = 20'h0; cpu_dout = 32'h0;
        ext_cs_b1 = 1'b1; cpu_rnw1 = 1'b1; cpu_addr1 = 20'h0; cpu_dout1 = 16'h0;
        test_reset;
        test_idle;
        test_read;
        test_write;
        test_back_to_back;
        test_single_beat;
        test_reset_midbeat;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
